// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package if_prefetch_pkg;

  // Fetch controller states.
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [31:0] NOP_CODE         = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // One prefetch-queue entry as seen by decode.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] code;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding {pc4, code} entries for the fetch front end.
// Flush has priority over push and pop; pushes land one cycle later (no bypass).
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [63:0]   data_i,
  output logic [63:0]   data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop on empty is ignored; a push on full only proceeds if a pop frees the slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to an
// in-order variable-latency memory, queues responses and hands them to decode.
// Handshake rule (both the memory request and the decode port): a transfer
// happens at a rising edge where valid and ready are both 1; the producer keeps
// valid and payload stable until that edge, except a redirect may withdraw a
// pending memory request.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_code,
  output logic [31:0] out_pc4,
  output logic [0:0]  dbg_state_o
);

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [0:0]    state_q, state_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [63:0]   fifo_rd_data;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [CW:0]   budget;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_pc_aligned;
  logic          unused_ok;

  assign redirect_pc_aligned = word_align(redirect_pc);
  assign unused_ok           = ^{redirect_pc[1:0], fifo_full};

  // Credits: queued entries plus outstanding requests never exceed DEPTH.
  // Only registered counts are used, so a dequeue frees a credit next cycle.
  assign budget = {1'b0, inflight_q} + {1'b0, fifo_count};

  // rst_n gates the request so it drops immediately on async reset.
  assign imem_req_valid = rst_n && (state_q == ST_FETCH) && (budget < LIMIT) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign head      = fifo_rd_data;
  assign out_valid = (state_q == ST_FETCH) && !fifo_empty;
  assign out_code  = out_valid ? head.code : NOP_CODE;
  assign out_pc4   = out_valid ? head.pc4 : 32'h0;
  assign pop       = out_valid && out_ready;

  // Responses are enqueued only in FETCH and never in a redirect cycle.
  // rsp_pc tracks the address of the oldest outstanding live request.
  assign push       = imem_rsp_valid && (state_q == ST_FETCH) && !redirect_valid;
  assign push_entry = '{pc4: rsp_pc_q + WORD_BYTES, code: imem_rsp_data};

  assign dbg_state_o = state_q;

  if_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_valid),
    .data_i (push_entry),
    .data_o (fifo_rd_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Next-state for fetch PC, response PC, credit counters and FSM.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;

    if (req_fire && !imem_rsp_valid) begin
      inflight_d = inflight_q + ONE;
    end else if (!req_fire && imem_rsp_valid && (inflight_q != '0)) begin
      inflight_d = inflight_q - ONE;
    end

    if (redirect_valid) begin
      // No request is accepted in a redirect cycle, so everything still
      // outstanding after this edge belongs to the old path.
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      drop_cnt_d = inflight_d;
      state_d    = (inflight_d != '0) ? ST_FLUSH : ST_FETCH;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + WORD_BYTES;
      if (push)     rsp_pc_d   = rsp_pc_q + WORD_BYTES;
      if (state_q == ST_FLUSH) begin
        if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - ONE;
        if (drop_cnt_d == '0) state_d = ST_FETCH;
      end
    end
  end

  // Fetch controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      state_q    <= ST_FETCH;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
    end
  end

  a_no_rsp_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (inflight_q != '0));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> !fifo_full);

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_valid && !imem_req_ready) |=>
      (redirect_valid || (imem_req_valid && $stable(imem_req_addr))));

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: per-cycle vector table plus hand-written
// sequences for address wrap and mid-stream reset. The memory model returns
// ~addr as the instruction word after a configurable fixed latency.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_code;
  logic [31:0] out_pc4;
  logic [0:0]  dbg_state;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  int          mem_lat = 1;
  int          mcyc = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  typedef struct {
    bit          rst;
    int          lat;
    bit          rdy;
    bit          ordy;
    bit          redir;
    logic [31:0] rpc;
    bit          erv;
    logic [31:0] eaddr;
    bit          eov;
    logic [31:0] epc4;
    bit          est;
  } vec_t;
  vec_t vecs[$];

  if_prefetch #(
    .DEPTH   (4),
    .RESET_PC(32'h0000_3000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_code      (out_code),
    .out_pc4       (out_pc4),
    .dbg_state_o   (dbg_state)
  );

  // Clock and watchdog.
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // In-order fixed-latency memory: handshakes sampled mid-cycle, response
  // driven 1 time unit after the edge, lat cycles after acceptance.
  initial begin
    logic        fire;
    logic        taken;
    logic [31:0] faddr;
    forever begin
      @(negedge clk);
      fire  = rst_n && imem_req_valid && imem_req_ready;
      faddr = imem_req_addr;
      taken = imem_rsp_valid;
      @(posedge clk);
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
      end else begin
        if (taken && pend_addr.size() > 0) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (fire) begin
          pend_addr.push_back(faddr);
          pend_due.push_back(mcyc + mem_lat);
        end
      end
      mcyc++;
      #1;
      if (rst_n && pend_addr.size() > 0 && pend_due[0] <= mcyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~pend_addr[0];
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int lat);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = lat;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic void add(bit rst, int lat, bit rdy, bit ordy, bit redir,
                              logic [31:0] rpc, bit erv, logic [31:0] eaddr,
                              bit eov, logic [31:0] epc4, bit est);
    vec_t v;
    v.rst = rst; v.lat = lat; v.rdy = rdy; v.ordy = ordy; v.redir = redir;
    v.rpc = rpc; v.erv = erv; v.eaddr = eaddr; v.eov = eov; v.epc4 = epc4;
    v.est = est;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] e;
    int          budget;

    // Stream: 1-cycle memory, everything ready.
    add(1, 1, 1, 1, 0, 0, 1, 32'h3000, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h3004, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(0, 1, 1, 1, 0, 0, 1, 32'h3008 + 4 * k, 1, 32'h3004 + 4 * k, 0);

    // Backpressure: decode stalled 10 cycles, then released.
    add(1, 1, 1, 0, 0, 0, 1, 32'h3000, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 32'h3004, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 32'h3008, 1, 32'h3004, 0);
    add(0, 1, 1, 0, 0, 0, 1, 32'h300C, 1, 32'h3004, 0);
    for (int k = 0; k < 6; k++)
      add(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h3004, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1, 32'h3004, 0);
    for (int k = 0; k < 4; k++)
      add(0, 1, 1, 1, 0, 0, 1, 32'h3010 + 4 * k, 1, 32'h3008 + 4 * k, 0);

    // Memory stall: request held for 5 cycles.
    for (int k = 0; k < 5; k++)
      add(k == 0, 1, 0, 1, 0, 0, 1, 32'h3000, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h3000, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h3004, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h3008, 1, 32'h3004, 0);

    // Redirect with two requests in flight, 3-cycle memory.
    add(1, 3, 1, 1, 0, 0, 1, 32'h3000, 0, 0, 0);
    add(0, 3, 1, 1, 0, 0, 1, 32'h3004, 0, 0, 0);
    add(0, 3, 1, 1, 1, 32'h4002, 0, 0, 0, 0, 0);
    add(0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 3, 1, 1, 0, 0, 1, 32'h4000, 0, 0, 0);
    add(0, 3, 1, 1, 0, 0, 1, 32'h4004, 0, 0, 0);
    add(0, 3, 1, 1, 0, 0, 1, 32'h4008, 0, 0, 0);
    add(0, 3, 1, 1, 0, 0, 1, 32'h400C, 0, 0, 0);
    add(0, 3, 1, 1, 0, 0, 0, 0, 1, 32'h4004, 0);

    // Redirect coinciding with a response and a dequeue, 2-cycle memory.
    add(1, 2, 1, 1, 0, 0, 1, 32'h3000, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0, 1, 32'h3004, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0, 1, 32'h3008, 0, 0, 0);
    add(0, 2, 1, 1, 1, 32'h5000, 0, 0, 1, 32'h3004, 0);
    add(0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 2, 1, 1, 0, 0, 1, 32'h5000, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0, 1, 32'h5004, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0, 1, 32'h5008, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0, 1, 32'h500C, 1, 32'h5004, 0);

    // Initial reset values.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_req_addr", imem_req_addr, 32'h3000);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_code", out_code, 0);
    chk("reset_out_pc4", out_pc4, 0);
    chk("reset_state", dbg_state, 0);
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset(vecs[i].lat);
      imem_req_ready = vecs[i].rdy;
      out_ready      = vecs[i].ordy;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d_req_valid", i), imem_req_valid, vecs[i].erv);
      if (vecs[i].erv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].eov);
      chk($sformatf("v%0d_out_pc4", i), out_pc4, vecs[i].epc4);
      chk($sformatf("v%0d_out_code", i), out_code,
          vecs[i].eov ? ~(vecs[i].epc4 - 32'd4) : 32'h0);
      chk($sformatf("v%0d_state", i), dbg_state, vecs[i].est);
      tick();
    end

    // Address wrap: redirect with nothing in flight to the top word.
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFD;
    @(negedge clk);
    chk("wrap_redir_req_valid", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_req_valid", imem_req_valid, 1);
    chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_state", dbg_state, 0);
    tick();
    @(negedge clk);
    chk("wrap_req_addr1", imem_req_addr, 32'h0000_0000);
    tick();
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0008);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("wrap_out_pc4", out_pc4, e);
        chk("wrap_out_code", out_code, ~(e - 32'd4));
      end
      budget++;
      tick();
    end
    chk("wrap_drain", exp_q.size(), 0);

    // Reset asserted mid-stream, then restart.
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", imem_req_valid, 0);
    chk("midrst_req_addr", imem_req_addr, 32'h3000);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_code", out_code, 0);
    chk("midrst_out_pc4", out_pc4, 0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req_valid", imem_req_valid, 1);
    chk("restart_req_addr0", imem_req_addr, 32'h3000);
    chk("restart_out_valid0", out_valid, 0);
    tick();
    @(negedge clk);
    chk("restart_req_addr1", imem_req_addr, 32'h3004);
    tick();
    @(negedge clk);
    chk("restart_out_valid2", out_valid, 1);
    chk("restart_out_pc4", out_pc4, 32'h3004);
    chk("restart_out_code", out_code, ~32'h3000);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
